// File: rtl/rv32_pkg.sv
// rv32_pkg: load size codes, writeback FSM states and the queued control entry
package rv32_pkg;
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RETIRE    = 2'd1,
        WAIT_LOAD = 2'd2
    } wb_state_e;

    typedef struct packed {
        logic [4:0] rd;
        logic       reg_write;
        logic       mem_to_reg;
        logic [2:0] funct3;
        logic [1:0] addr_lo;
    } wb_ctrl_t;

    function automatic logic reg_we(input wb_ctrl_t c);
        return c.reg_write && (c.rd != 5'd0);
    endfunction
endpackage

// File: rtl/load_extend.sv
// load_extend: selects the addressed byte/halfword of a load word and extends it
module load_extend
    import rv32_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2:0]            funct3_i,
    input  logic [1:0]            addr_lo_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] data_o
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = data_i[{addr_lo_i, 3'b000} +: 8];
    assign half_sel = data_i[{addr_lo_i[1], 4'b0000} +: 16];

    always_comb begin
        data_o = (funct3_i == F3_LB)  ? {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel} :
                 (funct3_i == F3_LBU) ? {{(DATA_WIDTH-8){1'b0}}, byte_sel} :
                 (funct3_i == F3_LH)  ? {{(DATA_WIDTH-16){half_sel[15]}}, half_sel} :
                 (funct3_i == F3_LHU) ? {{(DATA_WIDTH-16){1'b0}}, half_sel} :
                                        data_i;
    end
endmodule

// File: rtl/wb_writer.sv
// wb_writer: in-order writeback queue that retires ALU results and extended load data
module wb_writer
    import rv32_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [4:0]            i_rd,
    input  logic                  i_ctrl_RegWrite,
    input  logic                  i_ctrl_MemToReg,
    input  logic [2:0]            i_funct3,
    input  logic [1:0]            i_addr_lo,
    input  logic [DATA_WIDTH-1:0] i_alu_result,
    input  logic                  i_load_valid,
    input  logic [DATA_WIDTH-1:0] i_load_data,
    output logic [4:0]            o_rd,
    output logic [DATA_WIDTH-1:0] o_WriteData,
    output logic                  o_ctrl_RegWrite,
    output logic [31:0]           o_retired,
    output logic                  o_err
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    wb_ctrl_t              ctrl_mem [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] alu_mem  [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    wb_state_e             state_q, state_d;
    wb_ctrl_t              head;
    logic                  push, pop, next_is_load;
    logic [DATA_WIDTH-1:0] load_ext;

    assign o_ready = count_q < FULL;
    assign push    = i_valid && o_ready;
    assign head    = ctrl_mem[rd_ptr_q];
    // state_q already tells whether the head is complete, so pop needs no FIFO peek
    assign pop     = (state_q == RETIRE) || ((state_q == WAIT_LOAD) && i_load_valid);

    always_comb begin
        wr_ptr_d     = push ? ((wr_ptr_q == LAST) ? '0 : wr_ptr_q + PW'(1)) : wr_ptr_q;
        rd_ptr_d     = pop  ? ((rd_ptr_q == LAST) ? '0 : rd_ptr_q + PW'(1)) : rd_ptr_q;
        count_d      = count_q + CW'(push) - CW'(pop);
        // when the old contents drain this edge, the new head is the entry being accepted
        next_is_load = (count_q == CW'(pop)) ? i_ctrl_MemToReg : ctrl_mem[rd_ptr_d].mem_to_reg;
        state_d      = (count_d == '0) ? IDLE : next_is_load ? WAIT_LOAD : RETIRE;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ctrl_mem[wr_ptr_q] <= '{rd: i_rd, reg_write: i_ctrl_RegWrite, mem_to_reg: i_ctrl_MemToReg,
                                    funct3: i_funct3, addr_lo: i_addr_lo};
            alu_mem[wr_ptr_q]  <= i_alu_result;
        end
    end

    load_extend #(.DATA_WIDTH(DATA_WIDTH)) u_load_extend (
        .funct3_i  (head.funct3),
        .addr_lo_i (head.addr_lo),
        .data_i    (i_load_data),
        .data_o    (load_ext)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            state_q         <= IDLE;
            o_rd            <= '0;
            o_WriteData     <= '0;
            o_ctrl_RegWrite <= 1'b0;
            o_retired       <= '0;
            o_err           <= 1'b0;
        end else begin
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            state_q         <= state_d;
            o_ctrl_RegWrite <= pop && reg_we(head);
            if (pop) begin
                o_rd        <= head.rd;
                o_WriteData <= head.mem_to_reg ? load_ext : alu_mem[rd_ptr_q];
                o_retired   <= o_retired + 32'd1;
            end
            if (i_load_valid && (state_q != WAIT_LOAD))
                o_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_wb_writer.sv
// tb_wb_writer: scoreboard bench for the writeback queue
`timescale 1ns/1ps
module tb_wb_writer;
    import rv32_pkg::*;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        i_valid, o_ready;
    logic [4:0]  i_rd, o_rd;
    logic        i_ctrl_RegWrite, i_ctrl_MemToReg;
    logic [2:0]  i_funct3;
    logic [1:0]  i_addr_lo;
    logic [31:0] i_alu_result, i_load_data, o_WriteData, o_retired;
    logic        i_load_valid, o_ctrl_RegWrite, o_err;

    always #5 clk = ~clk;

    wb_writer #(.DATA_WIDTH(32), .FIFO_DEPTH(2)) dut (
        .clk             (clk),
        .n_rst           (n_rst),
        .i_valid         (i_valid),
        .o_ready         (o_ready),
        .i_rd            (i_rd),
        .i_ctrl_RegWrite (i_ctrl_RegWrite),
        .i_ctrl_MemToReg (i_ctrl_MemToReg),
        .i_funct3        (i_funct3),
        .i_addr_lo       (i_addr_lo),
        .i_alu_result    (i_alu_result),
        .i_load_valid    (i_load_valid),
        .i_load_data     (i_load_data),
        .o_rd            (o_rd),
        .o_WriteData     (o_WriteData),
        .o_ctrl_RegWrite (o_ctrl_RegWrite),
        .o_retired       (o_retired),
        .o_err           (o_err)
    );

    typedef struct {
        logic [4:0]  rd;
        logic        we;
        logic [31:0] data;
        int          acc;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          n_sent = 0;
    logic [31:0] ret_model = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ext_model(input logic [2:0] f3, input logic [1:0] alo, input logic [31:0] d);
        logic [31:0] b = (d >> (8 * alo)) & 32'hFF;
        logic [31:0] h = (d >> (16 * alo[1])) & 32'hFFFF;
        case (f3)
            3'b000:  return b[7] ? (b | 32'hFFFF_FF00) : b;
            3'b100:  return b;
            3'b001:  return h[15] ? (h | 32'hFFFF_0000) : h;
            3'b101:  return h;
            default: return d;
        endcase
    endfunction

    always @(negedge clk) begin
        if (n_rst) begin
            if (o_retired !== ret_model) begin
                if (sb.size() == 0) check("unexpected_retire", o_retired, ret_model);
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    ret_model = ret_model + 32'd1;
                    check("retired", o_retired, ret_model);
                    check("we", o_ctrl_RegWrite, e.we);
                    if (e.we) begin
                        check("rd", o_rd, e.rd);
                        check("wdata", o_WriteData, e.data);
                    end
                    if (e.lat > 0) check("latency", cyc - e.acc, e.lat);
                end
            end else check("no_pop_we", o_ctrl_RegWrite, 0);
        end
    end

    task automatic send(input logic [4:0] rd, input logic rw, input logic mtr, input logic [2:0] f3,
                        input logic [1:0] alo, input logic [31:0] alu, input logic [31:0] ldd, input int lat);
        exp_t e;
        int   n = 0;
        i_valid = 1'b1; i_rd = rd; i_ctrl_RegWrite = rw; i_ctrl_MemToReg = mtr;
        i_funct3 = f3; i_addr_lo = alo; i_alu_result = alu;
        while (!o_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("send_ready", o_ready, 1);
        if (o_ready) begin
            e.rd = rd; e.we = rw && (rd != 0); e.data = mtr ? ext_model(f3, alo, ldd) : alu;
            e.acc = cyc; e.lat = lat;
            sb.push_back(e);
            n_sent++;
        end
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    task automatic respond(input logic [31:0] d);
        i_load_valid = 1'b1; i_load_data = d;
        @(negedge clk);
        i_load_valid = 1'b0; i_load_data = '0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain", sb.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        n_rst = 1'b0; i_valid = 1'b0; i_rd = '0; i_ctrl_RegWrite = 1'b0; i_ctrl_MemToReg = 1'b0;
        i_funct3 = '0; i_addr_lo = '0; i_alu_result = '0; i_load_valid = 1'b0; i_load_data = '0;
        repeat (3) @(negedge clk);
        check("rst_we", o_ctrl_RegWrite, 0);
        check("rst_rd", o_rd, 0);
        check("rst_wdata", o_WriteData, 0);
        check("rst_retired", o_retired, 0);
        check("rst_err", o_err, 0);
        check("rst_ready", o_ready, 1);
        n_rst = 1'b1;
        @(negedge clk);

        send(5'd5, 1, 0, 3'b000, 2'd0, 32'h0000_00AA, 32'h0, 2);
        drain();
        check("retired_add", o_retired, 1);

        send(5'd3, 1, 1, F3_LB, 2'd2, 32'h0, 32'h1280_0000, 0);
        send(5'd9, 1, 0, 3'b000, 2'd0, 32'h1234_5678, 32'h0, 0);
        check("ready_full", o_ready, 0);
        repeat (2) @(negedge clk);
        check("ready_full_hold", o_ready, 0);
        respond(32'h1280_0000);
        drain();
        check("ready_after_drain", o_ready, 1);

        send(5'd7, 1, 1, F3_LHU, 2'd2, 32'h0, 32'h8001_0000, 0); respond(32'h8001_0000);
        send(5'd7, 1, 1, F3_LH,  2'd2, 32'h0, 32'h8001_0000, 0); respond(32'h8001_0000);
        send(5'd11, 1, 1, F3_LB,  2'd0, 32'h0, 32'h0000_007F, 0); respond(32'h0000_007F);
        send(5'd12, 1, 1, F3_LBU, 2'd3, 32'h0, 32'hAB00_0000, 0); respond(32'hAB00_0000);
        send(5'd13, 1, 1, F3_LH,  2'd0, 32'h0, 32'h0000_8000, 0); respond(32'h0000_8000);
        send(5'd14, 1, 1, F3_LW,  2'd1, 32'h0, 32'hDEAD_BEEF, 0); respond(32'hDEAD_BEEF);
        send(5'd15, 1, 1, 3'b011, 2'd0, 32'h0, 32'h1357_9BDF, 0); respond(32'h1357_9BDF);
        send(5'd16, 1, 1, F3_LB,  2'd1, 32'h0, 32'h0000_C300, 0); respond(32'h0000_C300);
        send(5'd17, 1, 1, F3_LHU, 2'd0, 32'h0, 32'hFFFF_F00D, 0); respond(32'hFFFF_F00D);
        drain();

        send(5'd0, 1, 0, 3'b000, 2'd0, 32'hFFFF_FFFF, 32'h0, 0);
        send(5'd4, 0, 0, 3'b000, 2'd0, 32'h5A5A_5A5A, 32'h0, 0);
        drain();
        check("retired_silent", o_retired, n_sent);

        for (int i = 0; i < 8; i++)
            send(5'(20 + i), 1, 0, 3'b000, 2'd0, 32'hC0DE_0000 + i, 32'h0, 0);
        send(5'd30, 1, 1, F3_LBU, 2'd1, 32'h0, 32'h0000_9900, 0);
        send(5'd31, 1, 0, 3'b000, 2'd0, 32'h0BAD_F00D, 32'h0, 0);
        respond(32'h0000_9900);
        drain();
        check("retired_stream", o_retired, n_sent);

        check("err_clear", o_err, 0);
        respond(32'h1111_1111);
        check("err_spurious", o_err, 1);
        repeat (2) @(negedge clk);

        send(5'd10, 1, 1, F3_LW, 2'd0, 32'h0, 32'h5555_5555, 0);
        repeat (2) @(negedge clk);
        n_rst = 1'b0;
        sb.delete();
        ret_model = '0;
        n_sent = 0;
        #1;
        check("midrst_we", o_ctrl_RegWrite, 0);
        check("midrst_rd", o_rd, 0);
        check("midrst_wdata", o_WriteData, 0);
        check("midrst_retired", o_retired, 0);
        check("midrst_err", o_err, 0);
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        check("post_rst_ready", o_ready, 1);
        check("post_rst_err", o_err, 0);
        respond(32'h5555_5555);
        check("late_load_err", o_err, 1);
        repeat (3) @(negedge clk);
        check("late_load_retired", o_retired, 0);

        check("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/wb_writer.md
WB_WRITER -- requirements
Module: wb_writer

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of the register write data path.
REQ-002 Parameter FIFO_DEPTH, default 2, number of retiring instructions buffered.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 n_rst  input  1  asynchronous, active-low reset.
REQ-005 i_valid  input  1  the MEM stage presents a retiring instruction.
REQ-006 o_ready  output  1  the block can accept an instruction this cycle.
REQ-007 i_rd  input  5  destination register index.
REQ-008 i_ctrl_RegWrite  input  1  the instruction writes the register file.
REQ-009 i_ctrl_MemToReg  input  1  the instruction is a load; its data comes from the load port.
REQ-010 i_funct3  input  3  load size and sign code.
REQ-011 i_addr_lo  input  2  byte offset of the load address.
REQ-012 i_alu_result  input  DATA_WIDTH  result for non-load instructions.
REQ-013 i_load_valid  input  1  in-order load response strobe from data memory.
REQ-014 i_load_data  input  DATA_WIDTH  raw aligned load word.
REQ-015 o_rd  output  5  register file write index.
REQ-016 o_WriteData  output  DATA_WIDTH  register file write data.
REQ-017 o_ctrl_RegWrite  output  1  register file write enable.
REQ-018 o_retired  output  32  count of retired instructions.
REQ-019 o_err  output  1  sticky flag for a protocol error.

Function
REQ-020 An instruction SHALL be accepted on a rising edge when i_valid and o_ready are both high.
REQ-021 o_ready SHALL be high exactly when the FIFO occupancy is below FIFO_DEPTH, and it SHALL NOT depend on a same-cycle pop.
REQ-022 A head entry SHALL be complete when i_ctrl_MemToReg was 0, or when i_ctrl_MemToReg was 1 and i_load_valid is high this cycle.
REQ-023 A complete head SHALL pop on the next edge, and its write SHALL appear on registered outputs in the following cycle.
REQ-024 The write enable SHALL follow the rule o_ctrl_RegWrite = RegWrite && rd != 0.
REQ-025 Minimum latency SHALL be 2 cycles, from the accept edge to o_ctrl_RegWrite high, when the FIFO is empty and the instruction is not a load.
REQ-026 Head FSM state IDLE SHALL mean the FIFO is empty.
REQ-027 Head FSM state RETIRE SHALL mean the head is complete.
REQ-028 Head FSM state WAIT_LOAD SHALL mean the head is a load with no response yet; the FSM SHALL leave WAIT_LOAD only on i_load_valid.
REQ-029 funct3 000 (LB) SHALL sign-extend the byte selected by addr_lo.
REQ-030 funct3 100 (LBU) SHALL zero-extend the byte selected by addr_lo.
REQ-031 funct3 001 (LH) and 101 (LHU) SHALL sign-extend and zero-extend respectively the halfword selected by addr_lo[1].
REQ-032 funct3 010 and every other code SHALL pass the full word through unchanged.
REQ-033 i_load_valid SHALL be ignored and o_err set when the head is not in WAIT_LOAD.
REQ-034 Simultaneous accept and pop SHALL keep the occupancy unchanged, and pointers SHALL wrap modulo FIFO_DEPTH.
REQ-035 o_retired SHALL increment once per pop, including pops with rd = 0 or RegWrite = 0, and SHALL wrap at 2^32.
REQ-036 o_ctrl_RegWrite SHALL be low in every cycle without a pop on the preceding edge.

Reset
REQ-037 While n_rst is low, the FIFO SHALL be flushed and the FSM SHALL be in IDLE.
REQ-038 While n_rst is low, o_ctrl_RegWrite, o_rd, o_WriteData, o_retired and o_err SHALL be 0.
REQ-039 Reset asserted mid-load SHALL discard the pending entry, and no write SHALL follow release.

Structure
REQ-040 funct3 load codes and FSM state encodings SHALL live in a shared package, rv32_pkg.
REQ-041 A single sub-module, load_extend, SHALL be purely combinational and perform byte and halfword selection and extension.

Verification
REQ-042 Scenario: ADD rd=5, alu=0x0000_00AA into an empty FIFO -> o_ctrl_RegWrite=1, o_rd=5, o_WriteData=0x0000_00AA two cycles after accept; o_retired=1.
REQ-043 Scenario: LB rd=3, addr_lo=2, load_data=0x1280_0000, response delayed 4 cycles -> o_ready low once two entries are queued; after the response, o_WriteData=0xFFFF_FF80.
REQ-044 Scenario: LHU rd=7, addr_lo=2, data=0x8001_0000 -> 0x0000_8001; LH with the same inputs -> 0xFFFF_8001.
REQ-045 Scenario: rd=0 with RegWrite=1 -> o_ctrl_RegWrite stays 0; o_retired still increments.
REQ-046 Scenario: i_load_valid pulsed with the FIFO empty -> o_err=1 and no write.
REQ-047 Scenario: reset asserted while in WAIT_LOAD -> all outputs 0 and o_ready=1 after release; a late i_load_valid sets o_err only.
